// File: rtl/ram2video_pkg.sv
// ram2video_pkg: 480p output timing, shared line-buffer RAM geometry and FSM state type.
package ram2video_pkg;
    localparam int H_ACTIVE     = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int H_TOTAL      = 800;
    localparam int V_ACTIVE     = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;
    localparam int V_TOTAL      = 525;
    localparam int RAM_AW       = 14;
    localparam int RAM_DW       = 24;
    localparam int LINE_LENGTH  = 640;
    localparam int RAM_NUMWORDS = 16000;
    localparam int RAM_LATENCY  = 2;
    localparam int CW           = 10;

    typedef enum logic {WAIT_TRIGGER, RUN} state_t;

    // Same wrap rule the capture-side writer applies to its line base.
    function automatic logic [RAM_AW-1:0] next_base(input logic [RAM_AW-1:0] b);
        return (b < RAM_AW'(RAM_NUMWORDS - LINE_LENGTH)) ? b + RAM_AW'(LINE_LENGTH) : '0;
    endfunction
endpackage

// File: rtl/ram2video_if.sv
// ram2video_if: line-buffer read port plus the regenerated RGB/DE/sync video bus.
interface ram2video_if;
    import ram2video_pkg::*;
    logic [RAM_AW-1:0] rdaddr;
    logic [RAM_DW-1:0] rddata;
    logic [7:0]        R, G, B;
    logic              video_de, hsync_n, vsync_n;
    modport master (output rdaddr, R, G, B, video_de, hsync_n, vsync_n, input rddata);
    modport slave  (input rdaddr, R, G, B, video_de, hsync_n, vsync_n, output rddata);
endinterface

// File: rtl/ram2video_delay_pipe.sv
// ram2video_delay_pipe: D-stage shift register of width W, reset to RST_VAL.
module ram2video_delay_pipe #(
    parameter int W = 1,
    parameter int D = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] stage [D];

    always_ff @(posedge clock or negedge nreset)
        if (!nreset) begin
            for (int i = 0; i < D; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
        end

    assign dout = stage[D-1];
endmodule

// File: rtl/ram2video.sv
// ram2video: replays buffered lines from the line-buffer RAM as a 640x480p raster.
// Define RAM2VIDEO_RESYNC_EN to let a starttrigger in RUN restart the raster.
module ram2video #(
    parameter int H_ACTIVE     = ram2video_pkg::H_ACTIVE,
    parameter int H_SYNC_START = ram2video_pkg::H_SYNC_START,
    parameter int H_SYNC_END   = ram2video_pkg::H_SYNC_END,
    parameter int H_TOTAL      = ram2video_pkg::H_TOTAL,
    parameter int V_ACTIVE     = ram2video_pkg::V_ACTIVE,
    parameter int V_SYNC_START = ram2video_pkg::V_SYNC_START,
    parameter int V_SYNC_END   = ram2video_pkg::V_SYNC_END,
    parameter int V_TOTAL      = ram2video_pkg::V_TOTAL,
    parameter int RAM_LATENCY  = ram2video_pkg::RAM_LATENCY
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        starttrigger,
    input  logic        line_doubler,
    ram2video_if.master bus
);
    import ram2video_pkg::*;

    state_t            state, state_nxt;
    logic [CW-1:0]     x, x_nxt, y, y_nxt;
    logic [RAM_AW-1:0] base, base_nxt;
    logic              ld_r, run, active, hs_raw, vs_raw, de_d, hs_d, vs_d;

    assign run    = state == RUN;
    assign active = run && x < CW'(H_ACTIVE) && y < CW'(V_ACTIVE);
    assign hs_raw = run && x >= CW'(H_SYNC_START) && x < CW'(H_SYNC_END);
    assign vs_raw = run && y >= CW'(V_SYNC_START) && y < CW'(V_SYNC_END);

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        base_nxt  = base;
        if (state == WAIT_TRIGGER)
            state_nxt = starttrigger ? RUN : WAIT_TRIGGER;
`ifdef RAM2VIDEO_RESYNC_EN
        else if (starttrigger) begin
            x_nxt    = '0;
            y_nxt    = '0;
            base_nxt = '0;
        end
`endif
        else begin
            x_nxt = (x == CW'(H_TOTAL - 1)) ? '0 : x + CW'(1);
            if (x == CW'(H_TOTAL - 1)) begin
                y_nxt    = (y == CW'(V_TOTAL - 1)) ? '0 : y + CW'(1);
                // Doubled lines hold the base on even y so the odd line replays it.
                base_nxt = (y == CW'(V_TOTAL - 1)) ? '0 :
                           (y < CW'(V_ACTIVE) && !(ld_r && !y[0])) ? next_base(base) : base;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset)
        if (!nreset) begin
            state      <= WAIT_TRIGGER;
            x          <= '0;
            y          <= '0;
            base       <= '0;
            ld_r       <= 1'b0;
            bus.rdaddr <= '0;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            base  <= base_nxt;
            ld_r  <= line_doubler;
            if (active) bus.rdaddr <= base + RAM_AW'(x);
        end

    // Address register and RAM latency; the output register supplies the last cycle.
    ram2video_delay_pipe #(.W(3), .D(RAM_LATENCY + 1), .RST_VAL(3'b000)) u_pipe (
        .clock (clock),
        .nreset(nreset),
        .din   ({active, hs_raw, vs_raw}),
        .dout  ({de_d, hs_d, vs_d})
    );

    always_ff @(posedge clock or negedge nreset)
        if (!nreset) begin
            {bus.R, bus.G, bus.B} <= '0;
            bus.video_de          <= 1'b0;
            bus.hsync_n           <= 1'b1;
            bus.vsync_n           <= 1'b1;
        end else begin
            {bus.R, bus.G, bus.B} <= de_d ? bus.rddata : '0;
            bus.video_de          <= de_d;
            bus.hsync_n           <= ~hs_d;
            bus.vsync_n           <= ~vs_d;
        end
endmodule

// File: tb/tb_ram2video.sv
// tb_ram2video: directed bench for ram2video against a cycle model and hand-computed checkpoints.
// The vertical raster is shortened so whole frames fit in a short run.
module tb_ram2video;
    import ram2video_pkg::*;

    localparam int VA = 26, VSS = 28, VSE = 30, VT = 31;

    logic clock = 1'b0, nreset = 1'b0, starttrigger = 1'b0, line_doubler = 1'b0;
    logic [23:0] r1;
    int nvec = 0, nerr = 0, k = 8, tn = 0;
    int mx, my, mbase;
    bit mrun, mld;
    bit hde [8], hhs [8], hvs [8];
    logic [13:0] haddr [8];

    ram2video_if bus();

    ram2video #(.V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .starttrigger(starttrigger),
        .line_doubler(line_doubler),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] pat(input logic [13:0] a);
        return {a[7:0], 2'b10, a[13:8], ~a[7:0]};
    endfunction

    // Two-cycle read latency RAM holding a pattern derived from the address.
    always @(posedge clock) begin
        r1          <= pat(bus.rdaddr);
        bus.rddata  <= r1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h (tn=%0d)", tag, obs, exp, tn);
        end
    endtask

    task automatic mreset();
        mrun = 0; mld = 0; mx = 0; my = 0; mbase = 0;
        for (int i = 0; i < 8; i++) begin
            hde[i] = 0; hhs[i] = 0; hvs[i] = 0; haddr[i] = '0;
        end
    endtask

    task automatic step();
        bit act;
        if (!nreset) begin
            mreset();
            k++;
            return;
        end
        act = mrun && mx < 640 && my < VA;
        hde[k&7] = act;
        hhs[k&7] = mrun && mx >= 656 && mx < 752;
        hvs[k&7] = mrun && my >= VSS && my < VSE;
        haddr[(k+1)&7] = act ? 14'(mbase + mx) : haddr[k&7];
        k++;
        if (!mrun) mrun = starttrigger;
`ifdef RAM2VIDEO_RESYNC_EN
        else if (starttrigger) begin
            mx = 0; my = 0; mbase = 0;
        end
`endif
        else if (mx < 799) mx++;
        else begin
            mx = 0;
            if (my == VT - 1) begin
                my = 0; mbase = 0;
            end else begin
                if (my < VA && !(mld && my % 2 == 0)) mbase = (mbase < 15360) ? mbase + 640 : 0;
                my++;
            end
        end
        mld = line_doubler;
    endtask

    task automatic check_all();
        bit de;
        de = hde[(k-4)&7];
        chk("rdaddr", 32'(bus.rdaddr), 32'(haddr[k&7]));
        chk("video_de", 32'(bus.video_de), 32'(de));
        chk("hsync_n", 32'(bus.hsync_n), 32'(!hhs[(k-4)&7]));
        chk("vsync_n", 32'(bus.vsync_n), 32'(!hvs[(k-4)&7]));
        chk("rgb", 32'({bus.R, bus.G, bus.B}), de ? 32'(pat(haddr[(k-3)&7])) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        step();
        @(negedge clock);
        tn++;
        check_all();
    endtask

    task automatic run_to(input int t);
        while (tn < t) tick();
    endtask

    initial begin
        mreset();
        repeat (3) tick();
        nreset = 1'b1;
        repeat (2000) tick();
        chk("idle_rdaddr", 32'(bus.rdaddr), 32'd0);
        chk("idle_de", 32'(bus.video_de), 32'd0);

        // Line doubler off: first frame, line bases and wrap.
        starttrigger = 1'b1;
        tn = 0;
        tick();
        starttrigger = 1'b0;
        run_to(2);
        chk("first_rdaddr", 32'(bus.rdaddr), 32'd0);
        run_to(4);
        chk("de_before_rise", 32'(bus.video_de), 32'd0);
        run_to(5);
        chk("de_rise", 32'(bus.video_de), 32'd1);
        run_to(641);
        chk("rdaddr_x639", 32'(bus.rdaddr), 32'd639);
        run_to(644);
        chk("de_last", 32'(bus.video_de), 32'd1);
        run_to(645);
        chk("de_fall", 32'(bus.video_de), 32'd0);
        run_to(660);
        chk("hsync_before", 32'(bus.hsync_n), 32'd1);
        run_to(661);
        chk("hsync_fall", 32'(bus.hsync_n), 32'd0);
        run_to(756);
        chk("hsync_last_low", 32'(bus.hsync_n), 32'd0);
        run_to(757);
        chk("hsync_rise", 32'(bus.hsync_n), 32'd1);
        run_to(802);
        chk("line1_base", 32'(bus.rdaddr), 32'd640);
        run_to(19202);
        chk("line24_base", 32'(bus.rdaddr), 32'd15360);
        run_to(20002);
        chk("line25_wrap", 32'(bus.rdaddr), 32'd0);
        run_to(24802);
        chk("frame2_base", 32'(bus.rdaddr), 32'd0);

        // Second trigger mid-line (frame 2, line 1, x=99).
        run_to(25700);
        starttrigger = 1'b1;
        tick();
        starttrigger = 1'b0;
        run_to(25702);
`ifdef RAM2VIDEO_RESYNC_EN
        chk("retrigger_addr", 32'(bus.rdaddr), 32'd0);
`else
        chk("retrigger_addr", 32'(bus.rdaddr), 32'd740);
`endif
        run_to(27000);
        chk("pre_reset_de", 32'(bus.video_de), 32'd1);

        // Asynchronous reset mid-line.
        #2 nreset = 1'b0;
        mreset();
        #1;
        chk("async_rdaddr", 32'(bus.rdaddr), 32'd0);
        chk("async_de", 32'(bus.video_de), 32'd0);
        chk("async_hsync", 32'(bus.hsync_n), 32'd1);
        chk("async_vsync", 32'(bus.vsync_n), 32'd1);
        chk("async_rgb", 32'({bus.R, bus.G, bus.B}), 32'd0);
        repeat (2) tick();
        nreset = 1'b1;
        repeat (2000) tick();
        chk("post_reset_idle", 32'(bus.video_de), 32'd0);

        // Line doubler on: bases 0,0,640,640,1280 and a two-line vsync.
        line_doubler = 1'b1;
        repeat (4) tick();
        starttrigger = 1'b1;
        tn = 0;
        tick();
        starttrigger = 1'b0;
        run_to(2);
        chk("ld_line0", 32'(bus.rdaddr), 32'd0);
        run_to(802);
        chk("ld_line1", 32'(bus.rdaddr), 32'd0);
        run_to(1602);
        chk("ld_line2", 32'(bus.rdaddr), 32'd640);
        run_to(2402);
        chk("ld_line3", 32'(bus.rdaddr), 32'd640);
        run_to(3202);
        chk("ld_line4", 32'(bus.rdaddr), 32'd1280);
        run_to(22404);
        chk("vsync_before", 32'(bus.vsync_n), 32'd1);
        run_to(22405);
        chk("vsync_fall", 32'(bus.vsync_n), 32'd0);
        run_to(24004);
        chk("vsync_last_low", 32'(bus.vsync_n), 32'd0);
        run_to(24005);
        chk("vsync_rise", 32'(bus.vsync_n), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
